// File: rtl/vga_timing_checker.sv
// Receive-side VGA timing checker: locks onto an h_sync/v_sync/video_on stream,
// recovers the pixel position and latches sticky timing-error flags.
module vga_timing_checker #(
  parameter int HD          = 640,
  parameter int HF          = 16,
  parameter int HB          = 48,
  parameter int HR          = 96,
  parameter int VD          = 480,
  parameter int VF          = 10,
  parameter int VB          = 33,
  parameter int VR          = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       video_on,
  input  logic       err_clr,
  output logic [9:0] x_loc,
  output logic [9:0] y_loc,
  output logic       locked,
  output logic       frame_start,
  output logic [4:0] err_flags
);
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam logic [9:0] X_MAX  = 10'(HT - 1);
  localparam logic [9:0] Y_MAX  = 10'(VT - 1);
  localparam logic [9:0] H_FALL = 10'(HD + HF);
  localparam logic [9:0] H_RISE = 10'(HD + HF + HR);
  localparam logic [9:0] V_FALL = 10'(VD + VF);
  localparam logic [9:0] V_RISE = 10'(VD + VF + VR);
  localparam logic [9:0] HD_L   = 10'(HD);
  localparam logic [9:0] VD_L   = 10'(VD);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [9:0] px, py, x_nxt, y_nxt;
  logic [3:0] good_cnt, good_nxt;
  logic       hs_q, vs_q, fs_nxt;
  logic       h_fall, h_rise, v_fall, v_rise, at_vfall, at_vrise;
  logic [4:0] err_new;

  assign locked = (state == LOCKED);

  // Predicted position and the per-tick timing checks against it
  always_comb begin
    px = (x_loc == X_MAX) ? 10'd0 : x_loc + 10'd1;
    py = y_loc;
    if (x_loc == X_MAX) py = (y_loc == Y_MAX) ? 10'd0 : y_loc + 10'd1;
    h_fall   = hs_q & ~h_sync;
    h_rise   = ~hs_q & h_sync;
    v_fall   = vs_q & ~v_sync;
    v_rise   = ~vs_q & v_sync;
    at_vfall = (px == 10'd0) && (py == V_FALL);
    at_vrise = (px == 10'd0) && (py == V_RISE);
    err_new  = '0;
    if (state != SEARCH) begin
      err_new[0] = h_fall != (px == H_FALL);
      err_new[1] = h_rise != (px == H_RISE);
      err_new[2] = v_fall != at_vfall;
      err_new[3] = v_rise != at_vrise;
      err_new[4] = (state == LOCKED) && (video_on != ((px < HD_L) && (py < VD_L)));
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_loc;
    y_nxt     = y_loc;
    good_nxt  = good_cnt;
    fs_nxt    = 1'b0;
    if (pix_en) begin
      x_nxt  = px;
      y_nxt  = py;
      // a tick that drops lock must not also announce a frame
      fs_nxt = locked && (px == 10'd0) && (py == 10'd0) && (err_new == '0);
      case (state)
        SEARCH: if (v_fall) begin
          x_nxt     = 10'd0;
          y_nxt     = V_FALL;
          good_nxt  = '0;
          state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          if (|err_new) state_nxt = SEARCH;
          else if (at_vfall) begin
            good_nxt = good_cnt + 4'd1;
            if (good_nxt == LOCK_N) state_nxt = LOCKED;
          end
        end
        LOCKED: if (|err_new) state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      x_loc       <= '0;
      y_loc       <= '0;
      good_cnt    <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      frame_start <= 1'b0;
      err_flags   <= '0;
    end else begin
      state       <= state_nxt;
      x_loc       <= x_nxt;
      y_loc       <= y_nxt;
      good_cnt    <= good_nxt;
      frame_start <= fs_nxt;
      if (pix_en) begin
        hs_q <= h_sync;
        vs_q <= v_sync;
      end
      // clear applies first so an error on the same clk survives
      err_flags <= (err_clr ? 5'd0 : err_flags) | (pix_en ? err_new : 5'd0);
    end
  end
endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker on a scaled-down raster (16x12 total)
// so several full frames fit in a short run; pix_en every 4th clk.
module tb_vga_timing_checker;
  localparam int HD = 8, HF = 2, HB = 3, HR = 3;
  localparam int VD = 6, VF = 2, VB = 2, VR = 2;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int H_SS = HD + HF, H_SE = HD + HF + HR;
  localparam int V_SS = VD + VF, V_SE = VD + VF + VR;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  logic       h_sync = 1'b1, v_sync = 1'b1, video_on = 1'b0, err_clr = 1'b0;
  logic [9:0] x_loc, y_loc;
  logic       locked, frame_start;
  logic [4:0] err_flags;

  int checks = 0, errors = 0;
  int gh = 0, gv = 0;   // generator position of the next pixel
  int s_h, s_v;         // pixel sampled by the most recent step

  vga_timing_checker #(.HD(HD), .HF(HF), .HB(HB), .HR(HR), .VD(VD), .VF(VF),
                       .VB(VB), .VR(VR), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .video_on(video_on), .err_clr(err_clr), .x_loc(x_loc), .y_loc(y_loc),
    .locked(locked), .frame_start(frame_start), .err_flags(err_flags));

  always #5 clk = ~clk;

  // One pixel tick; outputs are valid when this returns (negedge after the tick).
  task automatic step(input bit hs_short, input bit hold, input bit vs_kill,
                      input bit vid0, input bit clr);
    repeat (3) @(negedge clk);
    s_h = gh; s_v = gv;
    h_sync   = !(gh >= H_SS && gh < (hs_short ? H_SE - 1 : H_SE));
    v_sync   = vs_kill ? 1'b1 : !(gv >= V_SS && gv < V_SE);
    video_on = vid0 ? 1'b0 : (gh < HD && gv < VD);
    pix_en   = 1'b1;
    err_clr  = clr;
    @(negedge clk);
    pix_en  = 1'b0;
    err_clr = 1'b0;
    if (!hold) begin
      if (gh == HT - 1) begin
        gh = 0;
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end else gh = gh + 1;
    end
  endtask

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v) && n < 2 * FRAME) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++; errors++;
      $display("FAIL goto: position (%0d,%0d) not reached", h, v);
    end
  endtask

  task automatic relock(input logic [4:0] exp_flags, output int falls);
    bit bad = 0;
    falls = 0;
    for (int n = 0; n < 6 * FRAME; n++) begin
      step(0, 0, 0, 0, 0);
      if (s_h == 0 && s_v == V_SS) falls++;
      if (err_flags !== exp_flags) bad = 1;
      if (locked) break;
    end
    checks++;
    if (locked !== 1'b1 || bad) begin
      errors++;
      $display("FAIL relock: locked=%b flags=%b required flags=%b falls=%0d",
               locked, err_flags, exp_flags, falls);
    end
    checks++;
    if (falls != 3 || s_h != 0 || s_v != V_SS) begin
      errors++;
      $display("FAIL relock_point: locked after %0d falls at (%0d,%0d), required 3 at (0,%0d)",
               falls, s_h, s_v, V_SS);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({x_loc, y_loc, locked, frame_start, err_flags} !== 27'd0) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d locked=%b fs=%b flags=%b, required all 0",
               x_loc, y_loc, locked, frame_start, err_flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    int falls, fs_cnt = 0;
    bit bad = 0;
    relock(5'd0, falls);
    for (int n = 0; n < FRAME; n++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (x_loc !== 10'(s_h) || y_loc !== 10'(s_v) || locked !== 1'b1 ||
          err_flags !== 5'd0 || frame_start !== (s_h == 0 && s_v == 0)) begin
        errors++; bad = 1;
        $display("FAIL track: x=%0d y=%0d locked=%b fs=%b flags=%b, required (%0d,%0d) 1 %b 0",
                 x_loc, y_loc, locked, frame_start, err_flags, s_h, s_v, (s_h == 0 && s_v == 0));
      end
      if (frame_start) fs_cnt++;
      @(negedge clk);
      checks++;
      if (frame_start !== 1'b0) begin
        errors++;
        $display("FAIL fs_width: frame_start=%b one clk later, required 0", frame_start);
      end
      if (bad) break;
    end
    checks++;
    if (fs_cnt != 1) begin
      errors++;
      $display("FAIL fs_count: %0d pulses per frame, required 1", fs_cnt);
    end
  endtask

  task automatic test_h_width;
    int falls;
    goto(H_SE - 1, 2);
    step(1, 0, 0, 0, 0);
    checks++;
    if (err_flags !== 5'b00010 || locked !== 1'b0) begin
      errors++;
      $display("FAIL h_width: flags=%b locked=%b, required 00010 0", err_flags, locked);
    end
    relock(5'b00010, falls);
  endtask

  task automatic test_clr_idle;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_flags !== 5'd0) begin
      errors++;
      $display("FAIL clr_idle: flags=%b, required 00000", err_flags);
    end
  endtask

  task automatic test_v_period;
    int falls;
    goto(0, V_SS);
    step(0, 0, 1, 0, 0);
    checks++;
    if (err_flags !== 5'b00100 || locked !== 1'b0) begin
      errors++;
      $display("FAIL v_period: flags=%b locked=%b, required 00100 0", err_flags, locked);
    end
    while (gv >= V_SS && gv < V_SE) step(0, 0, 1, 0, 0);
    relock(5'b00100, falls);
  endtask

  task automatic test_video_and_clr;
    int falls;
    goto(3, 3);
    step(0, 0, 0, 1, 0);
    checks++;
    if (err_flags !== 5'b10000 || locked !== 1'b0) begin
      errors++;
      $display("FAIL video: flags=%b locked=%b, required 10000 0", err_flags, locked);
    end
    relock(5'b10000, falls);
    // repeat pixel 9 so the line runs one tick long and h_sync falls late
    goto(H_SS - 1, 5);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (err_flags !== 5'b00001 || locked !== 1'b0 || x_loc !== 10'(H_SS)) begin
      errors++;
      $display("FAIL h_period_clr: flags=%b locked=%b x=%0d, required 00001 0 %0d",
               err_flags, locked, x_loc, H_SS);
    end
    relock(5'b00001, falls);
  endtask

  task automatic test_reset_mid;
    int falls;
    goto(0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x_loc, y_loc, locked, frame_start, err_flags} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: x=%0d y=%0d locked=%b fs=%b flags=%b, required all 0",
               x_loc, y_loc, locked, frame_start, err_flags);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    relock(5'd0, falls);
  endtask

  initial begin
    test_reset;
    test_lock;
    test_h_width;
    test_clr_idle;
    test_v_period;
    test_clr_idle;
    test_video_and_clr;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
